// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state encoding and SPI mode constants
// for the sys_clk-domain SPI responder.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_slave_if_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one SPI pin plus an
// edge-detect register providing level, rise and fall strobes.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: mode-0 SPI responder in the sys_clk domain with a
// one-entry transmit buffer and pulsed receive words.
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int                 DATA_W      = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  IDLE_WORD   = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int FL_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);
    localparam logic [FL_W-1:0]  FLUSH = FL_W'(SYNC_STAGES + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi, mosi_rise, mosi_fall;
    logic unused_sig;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(sys_clk), .rst_n(sys_rst_n), .pin(spi_clk_i),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(sys_clk), .rst_n(sys_rst_n), .pin(spi_cs_i),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(sys_clk), .rst_n(sys_rst_n), .pin(spi_mosi_i),
        .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sig = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   buf_q;
    logic                buf_full_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                underrun_q;
    logic [FL_W-1:0]     flush_q;

    logic sample, shift_edge, cs_start;
    logic word_done, reload, load, capture;

    assign sample     = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

    // A CS already low at reset must not look like a fresh fall.
    assign cs_start  = cs_fall & (flush_q == FLUSH);

    assign word_done = (state_q == SHIFT) & sample
                     & (cnt_q == LAST - 1'b1) & ~cs_rise;
    assign reload    = (state_q == SHIFT) & shift_edge
                     & (cnt_q == LAST) & ~cs_rise;
    assign load      = ((state_q == LOAD) & ~cs_rise) | reload;
    assign capture   = tx_valid_i & (~buf_full_q | load);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   state_d = SHIFT;
            default: state_d = IDLE;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            flush_q    <= '0;
        end else begin
            if (flush_q != FLUSH) flush_q <= flush_q + 1'b1;
            rx_valid_q <= word_done;
            underrun_q <= load & ~buf_full_q;

            if (capture) begin
                buf_q      <= tx_data_i;
                buf_full_q <= 1'b1;
            end else if (load) begin
                buf_full_q <= 1'b0;
            end

            if (cs_rise) begin
                cnt_q   <= '0;
                tx_sh_q <= '0;
            end else if (load) begin
                tx_sh_q <= buf_full_q ? buf_q : IDLE_WORD;
                cnt_q   <= '0;
            end else if (state_q == SHIFT) begin
                if (sample) begin
                    rx_sh_q <= {rx_sh_q[DATA_W-2:0], mosi};
                    if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
                end
                if (shift_edge) tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end

            if (word_done) rx_data_q <= {rx_sh_q[DATA_W-2:0], mosi};
        end
    end

    assign spi_miso_o    = tx_sh_q[DATA_W-1];
    assign spi_miso_oe_o = (state_q != IDLE);
    assign busy_o        = (state_q != IDLE);
    assign tx_ready_o    = ~buf_full_q;
    assign tx_underrun_o = underrun_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed mode-0 master driving spi_slave_if with
// hand-computed expected words.
module tb_spi_slave_if;

    localparam int HALF  = 8;
    localparam int SETUP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, underrun;
    logic [7:0] rx_data;
    logic       rx_valid, busy;

    int errors = 0;
    int checks = 0;
    int rxv_n = 0;
    int und_n = 0;

    spi_slave_if dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .spi_clk_i(sclk), .spi_cs_i(cs), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .tx_underrun_o(underrun),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxv_n++;
        if (underrun) und_n++;
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        cyc(SETUP);
    endtask

    // last: CS rises together with the final SCLK fall.
    task automatic xfer(input logic [7:0] mo, input int nbits,
                        input bit last, input int inj,
                        input logic [7:0] inj_d,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            if (i == inj) begin
                tx_data  = inj_d;
                tx_valid = 1'b1;
                cyc(1);
                tx_valid = 1'b0;
                cyc(HALF - 1);
            end else begin
                cyc(HALF);
            end
            mi   = {mi[6:0], miso};
            sclk = 1'b1;
            cyc(HALF);
            sclk = 1'b0;
            if (last && i == nbits - 1) cs = 1'b1;
        end
        cyc(HALF);
    endtask

    task automatic preload(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_miso"}, 8'(miso), 8'h0);
        chk({p, "_oe"}, 8'(miso_oe), 8'h0);
        chk({p, "_ready"}, 8'(tx_ready), 8'h1);
        chk({p, "_underrun"}, 8'(underrun), 8'h0);
        chk({p, "_rx_data"}, rx_data, 8'h00);
        chk({p, "_rx_valid"}, 8'(rx_valid), 8'h0);
        chk({p, "_busy"}, 8'(busy), 8'h0);
    endtask

    initial begin
        logic [7:0] mi, mi2;
        int v0, u0;

        cyc(3);
        chk_reset("por");
        rst_n = 1'b1;
        cyc(6);

        // preloaded 0xA5 out, 0x38 in
        preload(8'hA5);
        v0 = rxv_n;
        frame_start();
        chk("t1_busy", 8'(busy), 8'h1);
        xfer(8'h38, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t1_rx", rx_data, 8'h38);
        chk("t1_rxv", 8'(rxv_n - v0), 8'd1);
        chk("t1_miso", mi, 8'hA5);

        // underrun: empty buffer sends IDLE_WORD
        u0 = und_n;
        frame_start();
        xfer(8'h6E, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t2_miso", mi, 8'h00);
        chk("t2_und", 8'(und_n - u0), 8'd1);
        chk("t2_rx", rx_data, 8'h6E);

        // back-to-back words, second tx word loaded mid-word
        preload(8'hC3);
        u0 = und_n;
        v0 = rxv_n;
        frame_start();
        xfer(8'h12, 8, 1'b0, 3, 8'h5A, mi);
        chk("t3_rx1", rx_data, 8'h12);
        chk("t3_rxv1", 8'(rxv_n - v0), 8'd1);
        xfer(8'h34, 8, 1'b1, -1, 8'h00, mi2);
        cyc(HALF);
        chk("t3_rx2", rx_data, 8'h34);
        chk("t3_rxv2", 8'(rxv_n - v0), 8'd2);
        chk("t3_miso1", mi, 8'hC3);
        chk("t3_miso2", mi2, 8'h5A);
        chk("t3_und", 8'(und_n - u0), 8'd0);

        // partial word discarded
        v0 = rxv_n;
        frame_start();
        xfer(8'h5C, 5, 1'b0, -1, 8'h00, mi);
        cs = 1'b1;
        cyc(HALF);
        chk("t4_rxv", 8'(rxv_n - v0), 8'd0);
        chk("t4_rx_hold", rx_data, 8'h34);
        chk("t4_busy", 8'(busy), 8'h0);
        frame_start();
        xfer(8'hFF, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t4_rx", rx_data, 8'hFF);

        // reset mid-word
        frame_start();
        xfer(8'hA7, 3, 1'b0, -1, 8'h00, mi);
        rst_n = 1'b0;
        cyc(1);
        chk_reset("mid");
        rst_n = 1'b1;
        v0 = rxv_n;
        xfer(8'hA7 << 3, 5, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t5_rxv", 8'(rxv_n - v0), 8'd0);
        chk("t5_rx_hold", rx_data, 8'h00);
        frame_start();
        xfer(8'h81, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t5_rx", rx_data, 8'h81);

        // capture during the LOAD consume cycle
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        cyc(1);
        tx_data  = 8'h11;
        frame_start();
        tx_valid = 1'b0;
        chk("t6_ready", 8'(tx_ready), 8'h0);
        xfer(8'h00, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t6_miso", mi, 8'h22);
        frame_start();
        xfer(8'h00, 8, 1'b1, -1, 8'h00, mi);
        cyc(HALF);
        chk("t6_miso2", mi, 8'h11);
        chk("t6_ready2", 8'(tx_ready), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI responder (slave) that sits on the far end of the `spi_dpi` master link and runs entirely in the `sys_clk` domain. It oversamples the external SPI pins through synchronizers and applies mode 0 (CPOL=0, CPHA=0), MSB first. It deserializes MOSI into parallel receive words and serializes a parallel transmit word onto MISO. A one-entry transmit buffer with a valid/ready handshake feeds the shifter, and each received word is presented as a single-cycle valid pulse.

## Interface
- `DATA_W`, 8, word length in bits (≥2)
- `SYNC_STAGES`, 2, flops per pin synchronizer (≥2)
- `IDLE_WORD`, 8'h00, word shifted out on transmit underrun (width `DATA_W`)

- `sys_clk`  in  1  system clock; single clock, all logic on its rising edge
- `sys_rst_n`  in  1  synchronous, active-low reset
- `spi_clk_i`  in  1  SPI clock from master, asynchronous to `sys_clk`
- `spi_cs_i`  in  1  chip select, active low, asynchronous
- `spi_mosi_i`  in  1  master-out data, asynchronous
- `spi_miso_o`  out  1  slave-out data
- `spi_miso_oe_o`  out  1  MISO output enable; high only while selected
- `tx_data_i`  in  DATA_W  next word to transmit
- `tx_valid_i`  in  1  `tx_data_i` valid
- `tx_ready_o`  out  1  transmit buffer empty
- `tx_underrun_o`  out  1  1-cycle pulse: word started with an empty buffer
- `rx_data_o`  out  DATA_W  last complete received word; held until the next word
- `rx_valid_o`  out  1  1-cycle pulse: `rx_data_o` updated
- `busy_o`  out  1  high while selected (state ≠ IDLE)

## Operation
- Pins pass through `SYNC_STAGES` synchronizers plus one edge-detect register. This yields `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise` strobes and synchronized `mosi`.
- The FSM, in package `spi_slave_pkg`, has three states:
  - IDLE: `cs_fall` → LOAD.
  - LOAD: one cycle. Copy the buffer (or `IDLE_WORD` if the buffer is empty, with a `tx_underrun_o` pulse) into the tx shifter. Mark the buffer empty. Clear the bit counter. Go to SHIFT.
  - SHIFT:
    - On `sclk_rise`, shift `mosi` into the rx shifter LSB and increment the counter.
    - On `sclk_fall`, shift the tx shifter left.
    - After the `DATA_W`-th `sclk_rise`: write `rx_data_o` and pulse `rx_valid_o`. The following `sclk_fall` performs a LOAD-equivalent reload in place of the shift, so back-to-back words need no CS toggle.
- `cs_rise` in any state → IDLE. A partial word is discarded: no `rx_valid_o`, `rx_data_o` unchanged, counter cleared. A transmit word already loaded is lost; the buffer is untouched.
- `spi_miso_o` = tx shifter MSB; `spi_miso_oe_o` = (state ≠ IDLE).
- Transmit buffer: `tx_ready_o` = buffer empty. `tx_valid_i & tx_ready_o` captures `tx_data_i`. If a load and a consume fall in the same cycle, the consume happens first, so the buffer stays full with the new word.
- Receive has no backpressure; a word not consumed before the next `rx_valid_o` is overwritten.
- Counter width is clog2(`DATA_W`+1); it wraps to 0 at reload.

## Timing
- Reset values: `spi_miso_o`=0, `spi_miso_oe_o`=0, `tx_ready_o`=1, `tx_underrun_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0. FSM is in IDLE, and all synchronizer flops reset to idle pin levels (clk=0, cs=1, mosi=0).
- Pin-to-strobe latency is `SYNC_STAGES`+1 `sys_clk` cycles.
- `rx_valid_o` rises 1 cycle after the strobe of the last `sclk_rise`.
- MISO first bit is valid `SYNC_STAGES`+2 cycles after CS falls. The master must leave at least `SYNC_STAGES`+3 `sys_clk` periods between CS fall and the first SCLK rise.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+1 `sys_clk` periods. With the defaults this gives sclk ≤ `sys_clk`/6.
- Reset asserted mid-transfer returns every output to its reset value on the next edge. A transfer still in progress after reset is ignored until the next CS fall.

## Structure
- `spi_slave_pkg` holds the state enum (IDLE, LOAD, SHIFT) and the SPI mode constants `SPI_CPOL=0` and `SPI_CPHA=0`.
- Sub-module `spi_pin_sync`: `SYNC_STAGES` synchronizer plus previous-value register, providing level, rise, and fall outputs. It is instantiated three times (sclk, cs, mosi).

## Test plan
- Preload 0xA5, CS low, master sends 0x38 → `rx_data_o`=0x38 with one `rx_valid_o` pulse; MISO bits 1,0,1,0,0,1,0,1.
- Empty buffer, one word → MISO carries 0x00 and `tx_underrun_o` pulses once; RX is still correct.
- Two back-to-back words 0x12, 0x34 without CS toggle, TX 0xC3 then 0x5A loaded mid-first-word → two `rx_valid_o` pulses; MISO carries 0xC3 then 0x5A.
- CS raised after 5 bits → no `rx_valid_o`, `rx_data_o` unchanged, `busy_o`=0; the next full word 0xFF is received correctly.
- `sys_rst_n` low for 1 cycle mid-word → all outputs take their reset values the next cycle; the rest of that word is ignored; the next CS-framed word 0x81 is received.
- `tx_valid_i` held with 0x11 in the same cycle as LOAD consumes 0x22 → 0x22 is sent; the buffer holds 0x11 and `tx_ready_o`=0.
